// File: rtl/mac_feeder.sv
// mac_feeder: buffers one input vector and streams (input, weight) pairs to a neuron for each of N_NEURON neurons.
module mac_feeder #(
  parameter int N_IN     = 128,
  parameter int N_NEURON = 10,
  parameter int WAIT_MAX = 1023
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load_valid,
  input  logic [15:0]                         load_data,
  output logic                                load_ready,
  input  logic                                flush,
  input  logic                                go,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [$clog2(N_IN*N_NEURON)-1:0]    w_addr,
  input  logic [15:0]                         w_data,
  output logic [15:0]                         mac_in,
  output logic [15:0]                         mac_weight,
  output logic                                mac_start,
  output logic                                mac_rst,
  input  logic                                neu_ready,
  input  logic [15:0]                         neu_out,
  output logic                                res_valid,
  output logic [15:0]                         res_data,
  output logic [$clog2(N_NEURON)-1:0]         res_idx
);
  localparam int AW = $clog2(N_IN*N_NEURON);
  localparam int IW = $clog2(N_NEURON);
  localparam int KW = $clog2(N_IN);
  localparam int CW = $clog2(N_IN+1);
  localparam int TW = $clog2(WAIT_MAX+1);
  typedef enum logic [2:0] {IDLE, PRIME, STREAM, WAIT, EMIT, DONE} state_t;
  state_t state, nxt;
  logic [15:0] buffer [N_IN];
  logic [CW-1:0] cnt;
  logic [IW-1:0] n;
  logic [KW-1:0] k;
  logic [TW-1:0] wcnt;
  logic [15:0] in_hold, w_hold;
  logic full, start, last_n, last_k, timeout, load;
  always_comb begin
    full = cnt == CW'(N_IN);
    start = state == IDLE && go && full;
    last_n = n == IW'(N_NEURON-1);
    last_k = k == KW'(N_IN-1);
    timeout = wcnt == TW'(WAIT_MAX);
    load_ready = state == IDLE && !full;
    load = load_valid && load_ready && !flush;
    busy = state != IDLE;
    done = state == DONE;
    mac_start = state == STREAM;
    mac_rst = state == PRIME;
    res_valid = state == EMIT;
    mac_in = mac_start ? buffer[k] : in_hold;
    mac_weight = mac_start ? w_data : w_hold;
    // the weight memory has one cycle of read latency, so the address leads the presented pair by one
    w_addr = AW'(n * N_IN + (mac_start ? k + 1 : 0));
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? PRIME : IDLE;
      PRIME:   nxt = STREAM;
      STREAM:  nxt = last_k ? WAIT : STREAM;
      WAIT:    nxt = (neu_ready || timeout) ? EMIT : WAIT;
      EMIT:    nxt = last_n ? DONE : PRIME;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) if (load) buffer[KW'(cnt)] <= load_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      n <= '0;
      k <= '0;
      wcnt <= '0;
      err <= 1'b0;
      res_data <= '0;
      res_idx <= '0;
      in_hold <= '0;
      w_hold <= '0;
    end else begin
      in_hold <= mac_in;
      w_hold <= mac_weight;
      k <= mac_start ? k + 1'b1 : '0;
      wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
      if (state == IDLE && flush) cnt <= '0;
      else if (load) cnt <= cnt + 1'b1;
      if (start) begin
        n <= '0;
        err <= 1'b0;
      end
      if (state == WAIT && (neu_ready || timeout)) begin
        res_data <= neu_ready ? neu_out : 16'h0000;
        res_idx <= n;
        if (!neu_ready) err <= 1'b1;
      end
      if (state == EMIT && !last_n) n <= n + 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed checks of load, streaming, result capture, timeout and reset for mac_feeder.
module tb_mac_feeder;
  localparam int N_IN = 128;
  localparam int N_NEURON = 2;
  localparam int WAIT_MAX = 20;
  logic clk = 0;
  logic rst, load_valid, flush, go, neu_ready;
  logic [15:0] load_data, neu_out, w_data, mac_in, mac_weight, res_data;
  logic load_ready, busy, done, err, mac_start, mac_rst, res_valid;
  logic [$clog2(N_IN*N_NEURON)-1:0] w_addr;
  logic [$clog2(N_NEURON)-1:0] res_idx;
  int checks = 0, errors = 0, acc, t;

  mac_feeder #(.N_IN(N_IN), .N_NEURON(N_NEURON), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .flush(flush), .go(go), .busy(busy), .done(done), .err(err), .w_addr(w_addr), .w_data(w_data),
    .mac_in(mac_in), .mac_weight(mac_weight), .mac_start(mac_start), .mac_rst(mac_rst),
    .neu_ready(neu_ready), .neu_out(neu_out), .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx)
  );

  always #5 clk = ~clk;
  // weight memory with one cycle read latency holding w[a] = a
  always @(posedge clk) w_data <= 16'(w_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int words, input logic [15:0] base, output int a);
    a = 0;
    load_valid = 1;
    for (int i = 0; i < words; i++) begin
      load_data = base + 16'(i);
      if (load_ready) a++;
      tick();
    end
    load_valid = 0;
  endtask

  task automatic run_neuron(input int nn, input logic [15:0] base, input int delay,
                            input logic [15:0] val, input logic [15:0] prev);
    chk("prime_mac_rst", mac_rst, 1);
    chk("prime_mac_start", mac_start, 0);
    chk("prime_w_addr", w_addr, nn * N_IN);
    tick();
    for (int k = 0; k < N_IN; k++) begin
      chk("pair", {mac_start, mac_in, mac_weight}, {1'b1, 16'(base + 16'(k)), 16'(nn * N_IN + k)});
      go = k == 10;
      neu_ready = k < 4;
      neu_out = 16'hdead;
      tick();
    end
    go = 0;
    neu_ready = 0;
    chk("wait_mac_start", mac_start, 0);
    chk("wait_hold_in", mac_in, base + 16'(N_IN - 1));
    chk("wait_hold_w", mac_weight, nn * N_IN + N_IN - 1);
    chk("ready_ignored", res_data, prev);
    for (int d = 0; d < delay; d++) begin
      chk("wait_res_valid", res_valid, 0);
      tick();
    end
    neu_ready = 1;
    neu_out = val;
    tick();
    neu_ready = 0;
    chk("emit_valid", res_valid, 1);
    chk("emit_data", res_data, val);
    chk("emit_idx", res_idx, nn);
    tick();
  endtask

  initial begin
    rst = 1; load_valid = 0; load_data = 0; flush = 0; go = 0; neu_ready = 0; neu_out = 0;
    tick();
    tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_mac", {mac_start, mac_rst, res_valid}, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_data", {mac_in, mac_weight, res_data}, 0);
    chk("rst_idx", res_idx, 0);

    load(127, 16'h0001, acc);
    chk("load127", acc, 127);
    go = 1;
    tick();
    go = 0;
    chk("go_short_busy", busy, 0);
    chk("go_short_mac_rst", mac_rst, 0);
    flush = 1;
    load_valid = 1;
    tick();
    flush = 0;
    load_valid = 0;
    load(130, 16'h0001, acc);
    chk("load_accepted", acc, 128);
    chk("load_full_ready", load_ready, 0);

    go = 1;
    tick();
    go = 0;
    chk("run_busy", busy, 1);
    run_neuron(0, 16'h0001, 5, 16'h8123, 16'h0000);
    run_neuron(1, 16'h0001, 2, 16'h1234, 16'h8123);
    chk("done_pulse", done, 1);
    chk("done_res_valid", res_valid, 0);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_err", err, 0);
    chk("idle_load_ready", load_ready, 0);
    chk("idle_res_hold", res_data, 16'h1234);

    go = 1;
    tick();
    go = 0;
    for (int nn = 0; nn < N_NEURON; nn++) begin
      for (int i = 0; i < N_IN + 1; i++) tick();
      chk("to_wait_start", mac_start, 0);
      if (nn == 0) chk("to_err_early", err, 0);
      t = 0;
      while (!res_valid && t < 100) begin
        tick();
        t++;
      end
      chk("to_cycles", t, WAIT_MAX + 1);
      chk("to_err", err, 1);
      chk("to_data", res_data, 16'h0000);
      chk("to_idx", res_idx, nn);
      tick();
    end
    chk("to_done", done, 1);
    tick();
    chk("err_sticky", err, 1);

    go = 1;
    tick();
    go = 0;
    chk("go_clears_err", err, 0);
    chk("rerun_busy", busy, 1);
    tick();
    for (int i = 0; i < 60; i++) tick();
    chk("pair60", {mac_start, mac_in}, {1'b1, 16'd61});
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_start", mac_start, 0);
    chk("mid_rst_ready", load_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", {mac_in, mac_weight}, 0);
    go = 1;
    tick();
    go = 0;
    chk("go_empty_busy", busy, 0);
    load(130, 16'h0200, acc);
    chk("reload_accepted", acc, 128);
    go = 1;
    tick();
    go = 0;
    chk("reload_prime", mac_rst, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("reload_pair", {mac_start, mac_in, mac_weight}, {1'b1, 16'(16'h0200 + 16'(k)), 16'(k)});
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
